// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i constants, write-back entry type and register one-hot helper
package rv32i_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // One buffered write-back: destination register plus the value to commit.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   // One-hot register select with x0 masked off, since x0 is never tracked or written.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] m;
      m     = '0;
      m[rd] = (rd != '0);
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO holding load responses until the write port is free
module wb_fifo
   import rv32i_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_entry_t
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t head,
   output logic   full,
   output logic   empty
);

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // Status comes from the occupancy count alone; a same-cycle pop never frees a slot early.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; reset drops any buffered entries.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful between push and pop, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register file write port arbiter with load buffer and pending-load scoreboard
module writeback_unit
   import rv32i_pkg::*;
#(
   parameter int WIDTH    = XLEN,
   parameter int LQ_DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             alu_valid,
   input  logic [4:0]       alu_rd,
   input  logic [WIDTH-1:0] alu_data,
   input  logic             issue_valid,
   input  logic [4:0]       issue_rd,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [4:0]       mem_rd,
   input  logic [WIDTH-1:0] mem_data,
   output logic             write_en,
   output logic [4:0]       rd_addr,
   output logic [WIDTH-1:0] write_data,
   output logic [31:0]      pending_mask,
   output logic             protocol_err
);

   // Same layout as wb_entry_t, but sized by this instance's data width.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WIDTH-1:0]      data;
   } lq_entry_t;

   lq_entry_t           lq_in;
   lq_entry_t           lq_head;
   logic                lq_full;
   logic                lq_empty;
   logic                lq_push;
   logic                lq_pop;

   logic                stage_valid;
   logic [4:0]          stage_rd;
   logic [WIDTH-1:0]    stage_data;
   logic                stage_we;

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic                err_alu;
   logic                err_resp;
   logic                err_issue;

   assign mem_ready  = !lq_full;
   assign lq_push    = mem_valid && !lq_full;
   assign lq_in.rd   = mem_rd;
   assign lq_in.data = mem_data;

   wb_fifo #(
      .DEPTH   (LQ_DEPTH),
      .entry_t (lq_entry_t)
   ) u_lq (
      .clock     (clock),
      .reset     (reset),
      .push      (lq_push),
      .push_data (lq_in),
      .pop       (lq_pop),
      .head      (lq_head),
      .full      (lq_full),
      .empty     (lq_empty)
   );

   // Arbiter: the ALU has no backpressure so it always wins; loads drain only in ALU bubbles.
   always_comb begin
      stage_valid = 1'b0;
      stage_rd    = '0;
      stage_data  = '0;
      lq_pop      = 1'b0;
      if (alu_valid) begin
         stage_valid = 1'b1;
         stage_rd    = alu_rd;
         stage_data  = alu_data;
      end else if (!lq_empty) begin
         lq_pop      = 1'b1;
         stage_valid = 1'b1;
         stage_rd    = lq_head.rd;
         stage_data  = lq_head.data;
      end
   end

   // Writes to x0 are consumed (a load to x0 still pops) but never reach the register file.
   assign stage_we = stage_valid && (stage_rd != '0);

   // Scoreboard deltas; a load's bit clears on the cycle its data is staged for write.
   assign set_mask = issue_valid ? reg_onehot(issue_rd) : '0;
   assign clr_mask = lq_pop ? reg_onehot(lq_head.rd) : '0;

   // Protocol checks against the scoreboard as it stands before this edge; bit 0 is never set.
   assign err_alu   = alu_valid && pending_mask[alu_rd];
   assign err_resp  = lq_push && (mem_rd != '0) && !pending_mask[mem_rd];
   assign err_issue = issue_valid && pending_mask[issue_rd];

   // Registered write port; address and data hold whenever nothing is written.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         write_en   <= 1'b0;
         rd_addr    <= '0;
         write_data <= '0;
      end else begin
         write_en <= stage_we;
         if (stage_we) begin
            rd_addr    <= stage_rd;
            write_data <= stage_data;
         end
      end
   end

   // Pending-load scoreboard; a same-cycle set beats a clear of the same bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_mask <= '0;
      end else begin
         pending_mask <= (pending_mask & ~clr_mask) | set_mask;
      end
   end

   // Sticky protocol error flag, cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         protocol_err <= 1'b0;
      end else if (err_alu || err_resp || err_issue) begin
         protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - randomized scoreboard bench for writeback_unit
module tb_writeback_unit;

   localparam int WIDTH    = 32;
   localparam int LQ_DEPTH = 2;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             alu_valid = 1'b0;
   logic [4:0]       alu_rd = '0;
   logic [WIDTH-1:0] alu_data = '0;
   logic             issue_valid = 1'b0;
   logic [4:0]       issue_rd = '0;
   logic             mem_valid = 1'b0;
   logic             mem_ready;
   logic [4:0]       mem_rd = '0;
   logic [WIDTH-1:0] mem_data = '0;
   logic             write_en;
   logic [4:0]       rd_addr;
   logic [WIDTH-1:0] write_data;
   logic [31:0]      pending_mask;
   logic             protocol_err;

   always #5 clock = ~clock;

   writeback_unit #(
      .WIDTH    (WIDTH),
      .LQ_DEPTH (LQ_DEPTH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .write_en     (write_en),
      .rd_addr      (rd_addr),
      .write_data   (write_data),
      .pending_mask (pending_mask),
      .protocol_err (protocol_err)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ld_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   ld_t        m_lq[$];
   wr_t        exp_q[$];
   logic [4:0] awaiting[$];
   logic [31:0] m_pend = '0;
   logic        m_err = 1'b0;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   bit          done = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic logic [4:0] front_rd();
      if (awaiting.size() > 0) return awaiting[0];
      return 5'd0;
   endfunction

   // One clock of stimulus; the reference model predicts what the next edge does.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ird,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      logic        acc;
      logic [31:0] clr;
      ld_t         e;
      bit          found;
      @(negedge clock);
      chk("mem_ready", 32'(mem_ready), 32'(m_lq.size() < LQ_DEPTH));
      chk("pending_mask", pending_mask, m_pend);
      chk("protocol_err", 32'(protocol_err), 32'(m_err));
      alu_valid = av; alu_rd = ard; alu_data = ad;
      issue_valid = iv; issue_rd = ird;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      acc = mv && (m_lq.size() < LQ_DEPTH);
      if (av && ard != 0 && m_pend[ard]) m_err = 1'b1;
      if (acc && mrd != 0 && !m_pend[mrd]) m_err = 1'b1;
      if (iv && ird != 0 && m_pend[ird]) m_err = 1'b1;
      clr = '0;
      if (av) begin
         if (ard != 0) exp_q.push_back('{rd: ard, data: ad, cyc: cyc + 1});
      end else if (m_lq.size() > 0) begin
         e = m_lq.pop_front();
         if (e.rd != 0) begin
            exp_q.push_back('{rd: e.rd, data: e.data, cyc: cyc + 1});
            clr[e.rd] = 1'b1;
         end
      end
      if (acc) begin
         m_lq.push_back('{rd: mrd, data: md});
         found = 1'b0;
         for (int i = 0; i < awaiting.size(); i++) begin
            if (!found && awaiting[i] == mrd) begin
               awaiting.delete(i);
               found = 1'b1;
            end
         end
      end
      m_pend = m_pend & ~clr;
      if (iv && ird != 0) begin
         m_pend[ird] = 1'b1;
         awaiting.push_back(ird);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      #2;
      reset = 1'b0;
      alu_valid = 1'b0; issue_valid = 1'b0; mem_valid = 1'b0;
      #1;
      chk("rst_write_en", 32'(write_en), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_write_data", write_data, 32'd0);
      chk("rst_pending_mask", pending_mask, 32'd0);
      chk("rst_mem_ready", 32'(mem_ready), 32'd1);
      chk("rst_protocol_err", 32'(protocol_err), 32'd0);
      m_lq.delete(); exp_q.delete(); awaiting.delete();
      m_pend = '0; m_err = 1'b0;
      repeat (2) @(negedge clock);
      #2;
      reset = 1'b1;
   endtask

   // Monitor: every write the DUT presents must match the oldest expected write, on its cycle.
   initial begin
      wr_t w;
      while (!done) begin
         @(negedge clock);
         if (reset && !done) begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
               w = exp_q.pop_front();
               chk("write_en", 32'(write_en), 32'd1);
               if (write_en) begin
                  chk("rd_addr", 32'(rd_addr), 32'(w.rd));
                  chk("write_data", write_data, w.data);
               end
            end else begin
               chk("write_en_idle", 32'(write_en), 32'd0);
            end
         end
      end
   end

   initial begin
      apply_reset();

      // single ALU write
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      idle(3);

      // load round trip to x7
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678);
      idle(3);

      // ALU burst while three responses arrive
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd0, 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 5'd0, 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'(20 + i), $urandom, 1'b0, 5'd0, awaiting.size() > 0, front_rd(), $urandom);
      for (int i = 0; i < 6; i++)
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, awaiting.size() > 0, front_rd(), $urandom);
      idle(3);

      // x0 writes from both sources, then a load that must follow the x0 entry promptly
      step(1'b1, 5'd0, 32'hCAFEF00D, 1'b1, 5'd8, 1'b1, 5'd0, 32'h0BADF00D);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h88888888);
      idle(4);

      // randomized legal traffic
      for (int n = 0; n < 3000; n++) begin
         logic       av, iv, mv;
         logic [4:0] ard, ird, mrd;
         av  = ($urandom_range(0, 9) < 6);
         ard = 5'($urandom_range(0, 31));
         if (m_pend[ard]) ard = 5'd0;
         iv  = ($urandom_range(0, 3) == 0);
         ird = 5'($urandom_range(1, 31));
         if (m_pend[ird]) iv = 1'b0;
         mv  = 1'b0;
         mrd = 5'd0;
         if (awaiting.size() > 0 && $urandom_range(0, 9) < 6) begin
            mv  = 1'b1;
            mrd = awaiting[0];
         end else if ($urandom_range(0, 19) == 0) begin
            mv = 1'b1;
         end
         step(av, ard, $urandom, iv, ird, mv, mrd, $urandom);
      end
      idle(4);
      apply_reset();

      // two buffered loads behind ALU traffic, then reset mid-stream
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
      step(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 1'b1, 5'd3, 32'h33);
      step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44);
      apply_reset();
      idle(4);

      // ALU write to a pending register
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
      step(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      idle(4);
      apply_reset();

      // response to a register with no outstanding load
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99);
      idle(4);
      apply_reset();

      // second issue to an already pending register
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0);
      idle(4);
      chk("exp_drained", 32'(exp_q.size()), 32'd0);
      apply_reset();

      done = 1'b1;
      @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
